fetch_ctrl: RTL

- Fetch sequencer for the dual-issue front end.
- Owns the PC and the instruction-memory request handshake (one outstanding request, 64-bit / two-instruction fetch block).
- Drives the issue/in1/in2 write side of the 4-entry instruction buffer and tracks buffer occupancy with credits, so it never overfills the buffer.
- Handles branch redirect, including discarding an in-flight wrong-path response.

---
 rtl/fetch_ctrl_pkg.sv | 20 ++
 rtl/fetch_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: FSM states, issue encodings, bus widths.
package fetch_ctrl_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    localparam logic [1:0] ISSUE_NONE = 2'b00;
    localparam logic [1:0] ISSUE_ONE  = 2'b10;
    localparam logic [1:0] ISSUE_TWO  = 2'b11;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, the single-outstanding imem handshake and the
// credit-tracked write side of the instruction buffer, with branch redirect.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned     BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_flag,
    input  logic [PC_W-1:0]   branch_target,
    input  logic              launch_flag1,
    input  logic              launch_flag2,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [63:0]       imem_rdata,
    output logic [1:0]        issue,
    output logic [INST_W-1:0] in1_inst,
    output logic [PC_W-1:0]   in1_pc,
    output logic [PC_W-1:0]   in1_npc,
    output logic [INST_W-1:0] in2_inst,
    output logic [PC_W-1:0]   in2_pc,
    output logic [PC_W-1:0]   in2_npc,
    output logic              stop
);

    localparam logic [3:0] DEPTH = 4'(BUF_DEPTH);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [2:0]      occ;

    logic [1:0] need;
    logic [1:0] launched;
    logic [1:0] issued;
    logic [3:0] free;
    logic       credit_ok;
    logic       fire;
    logic [3:0] occ_sum;
    logic [3:0] occ_sub;
    logic [2:0] occ_next;
    logic [3:0] pc_step;

    assign need      = pc[2] ? 2'd1 : 2'd2;
    assign launched  = launch_flag2 ? 2'd2 : (launch_flag1 ? 2'd1 : 2'd0);
    assign free      = DEPTH - {1'b0, occ};
    assign credit_ok = free >= {2'b00, need};
    assign pc_step   = pc[2] ? 4'd4 : 4'd8;

    // Response is written only when neither reset nor a redirect squashes it.
    assign fire = rst && !branch_flag && (state == S_WAIT) && imem_rvalid;

    assign imem_req  = (state == S_REQ);
    assign imem_addr = {pc[PC_W-1:3], 3'b000};
    assign stop      = (state == S_IDLE) && !credit_ok;

    always_comb begin
        issue    = ISSUE_NONE;
        in1_inst = '0;
        in1_pc   = '0;
        in1_npc  = '0;
        in2_inst = '0;
        in2_pc   = '0;
        in2_npc  = '0;
        if (fire) begin
            in1_pc  = pc;
            in1_npc = pc + 32'd4;
            if (!pc[2]) begin
                issue    = ISSUE_TWO;
                in1_inst = imem_rdata[31:0];
                in2_inst = imem_rdata[63:32];
                in2_pc   = pc + 32'd4;
                in2_npc  = pc + 32'd8;
            end else begin
                issue    = ISSUE_ONE;
                in1_inst = imem_rdata[63:32];
            end
        end
    end

    // Occupancy floors at zero and saturates at the buffer depth.
    always_comb begin
        issued  = 2'(issue[1]) + 2'(issue[0]);
        occ_sum = {1'b0, occ} + {2'b00, issued};
        occ_sub = (occ_sum < {2'b00, launched}) ? 4'd0 : occ_sum - {2'b00, launched};
        occ_next = (occ_sub > DEPTH) ? DEPTH[2:0] : occ_sub[2:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            occ   <= '0;
        end else begin
            assert ({1'b0, occ} <= DEPTH);
            if (branch_flag) begin
                pc  <= branch_target;
                occ <= '0;
                case (state)
                    S_IDLE: state <= S_IDLE;
                    S_REQ:  state <= imem_gnt ? S_DROP : S_IDLE;
                    S_WAIT: state <= imem_rvalid ? S_IDLE : S_DROP;
                    S_DROP: state <= imem_rvalid ? S_IDLE : S_DROP;
                    default: state <= S_IDLE;
                endcase
            end else begin
                occ <= occ_next;
                case (state)
                    S_IDLE: if (credit_ok) state <= S_REQ;
                    S_REQ:  if (imem_gnt) state <= S_WAIT;
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            pc    <= pc + {28'b0, pc_step};
                            state <= S_IDLE;
                        end
                    end
                    S_DROP: if (imem_rvalid) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
